// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin selection of one producer result per cycle,
// registered into the integer register file write port, with a commit counter.
module wb_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int XLEN      = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_PORTS-1:0]      wb_valid_i,
  output logic [NUM_PORTS-1:0]      wb_ready_o,
  input  logic [NUM_PORTS*5-1:0]    wb_idx_i,
  input  logic [NUM_PORTS*XLEN-1:0] wb_data_i,
  output logic                      we_o,
  output logic [4:0]                rd_idx_o,
  output logic [XLEN-1:0]           rd_o,
  output logic [31:0]               wb_cnt_o
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand_idx;
  logic             any_valid;
  logic [4:0]       sel_idx;
  logic [XLEN-1:0]  sel_data;
  int               cand;

  // Scan offsets from the highest down so the smallest offset from rr_ptr wins.
  always_comb begin
    any_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
      cand_idx = PTR_W'(cand);
      if (wb_valid_i[cand_idx]) begin
        any_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    sel_idx    = '0;
    sel_data   = '0;
    wb_ready_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win_idx == PTR_W'(i)) begin
        sel_idx       = wb_idx_i[i*5 +: 5];
        sel_data      = wb_data_i[i*XLEN +: XLEN];
        wb_ready_o[i] = any_valid & ~rst_i;
      end
    end
  end

  assign ptr_nxt = (win_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : win_idx + PTR_W'(1);

  // x0 results still complete the handshake but never raise the write enable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr   <= '0;
      we_o     <= 1'b0;
      rd_idx_o <= '0;
      rd_o     <= '0;
      wb_cnt_o <= '0;
    end else if (any_valid) begin
      rr_ptr   <= ptr_nxt;
      rd_idx_o <= sel_idx;
      rd_o     <= sel_data;
      we_o     <= (sel_idx != 5'd0);
      if (sel_idx != 5'd0) begin
        wb_cnt_o <= wb_cnt_o + 32'd1;
      end
    end else begin
      we_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, reset/fairness
// sequences, and randomized traffic against a distance-based round-robin model.
module tb_wb_arbiter;

  localparam int N    = 3;
  localparam int XLEN = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [N-1:0]      wb_valid_i;
  logic [N-1:0]      wb_ready_o;
  logic [N*5-1:0]    wb_idx_i;
  logic [N*XLEN-1:0] wb_data_i;
  logic              we_o;
  logic [4:0]        rd_idx_o;
  logic [XLEN-1:0]   rd_o;
  logic [31:0]       wb_cnt_o;

  always #5 clk_i = ~clk_i;

  wb_arbiter #(.NUM_PORTS(N), .XLEN(XLEN)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wb_valid_i (wb_valid_i),
    .wb_ready_o (wb_ready_o),
    .wb_idx_i   (wb_idx_i),
    .wb_data_i  (wb_data_i),
    .we_o       (we_o),
    .rd_idx_o   (rd_idx_o),
    .rd_o       (rd_o),
    .wb_cnt_o   (wb_cnt_o)
  );

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] idx;
    logic [95:0] data;
    logic [2:0]  ready;
    logic        we;
    logic [4:0]  rd_idx;
    logic [31:0] rd;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[9];

  int n_chk  = 0;
  int n_pass = 0;

  // reference state
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_idx;
  logic [31:0] m_rd;
  logic [31:0] m_cnt;
  logic [2:0]  last_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_we = 1'b0; m_idx = '0; m_rd = '0; m_cnt = '0;
  endtask

  // winner = valid port at the smallest forward distance from the pointer
  function automatic int model_winner(input logic [2:0] v);
    int best  = -1;
    int bestd = N;
    for (int k = 0; k < N; k++) begin
      if (v[k]) begin
        int d = (k - m_ptr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = k;
        end
      end
    end
    return best;
  endfunction

  function automatic vec_t mk(input logic [2:0] v, input logic [14:0] ix, input logic [95:0] d,
                              input logic [2:0] r, input logic we, input logic [4:0] ri,
                              input logic [31:0] rd, input logic [31:0] c);
    vec_t t;
    t.valid = v; t.idx = ix; t.data = d; t.ready = r;
    t.we = we; t.rd_idx = ri; t.rd = rd; t.cnt = c;
    return t;
  endfunction

  // called at posedge+1; returns at the following posedge+1
  task automatic step(input logic [2:0] v, input logic [14:0] ix, input logic [95:0] d, input int row);
    int         w;
    logic [2:0] er;
    wb_valid_i = v; wb_idx_i = ix; wb_data_i = d;
    #2;
    w  = model_winner(v);
    er = (w >= 0) ? 3'(1 << w) : 3'b000;
    if (row >= 0) er = tbl[row].ready;
    last_ready = wb_ready_o;
    chk("ready", 32'(wb_ready_o), 32'(er));
    @(posedge clk_i);
    if (w >= 0) begin
      m_idx = ix[w*5 +: 5];
      m_rd  = d[w*32 +: 32];
      m_we  = (m_idx != 5'd0);
      if (m_we) m_cnt = m_cnt + 32'd1;
      m_ptr = (w + 1) % N;
    end else begin
      m_we = 1'b0;
    end
    #1;
    if (row >= 0) begin
      chk("we", 32'(we_o), 32'(tbl[row].we));
      chk("rd_idx", 32'(rd_idx_o), 32'(tbl[row].rd_idx));
      chk("rd", rd_o, tbl[row].rd);
      chk("cnt", wb_cnt_o, tbl[row].cnt);
    end else begin
      chk("we", 32'(we_o), 32'(m_we));
      chk("rd_idx", 32'(rd_idx_o), 32'(m_idx));
      chk("rd", rd_o, m_rd);
      chk("cnt", wb_cnt_o, m_cnt);
    end
  endtask

  logic [2:0]  pv;
  logic [4:0]  pidx [N];
  logic [31:0] pdat [N];
  logic [14:0] rix;
  logic [95:0] rdat;
  int          rw;

  initial begin
    tbl[0] = mk(3'b111, {5'd3, 5'd2, 5'd1}, {32'hA2, 32'hA1, 32'hA0}, 3'b001, 1'b1, 5'd1, 32'hA0, 32'd1);
    tbl[1] = mk(3'b111, {5'd3, 5'd2, 5'd1}, {32'hA2, 32'hA1, 32'hA0}, 3'b010, 1'b1, 5'd2, 32'hA1, 32'd2);
    tbl[2] = mk(3'b111, {5'd3, 5'd2, 5'd1}, {32'hA2, 32'hA1, 32'hA0}, 3'b100, 1'b1, 5'd3, 32'hA2, 32'd3);
    tbl[3] = mk(3'b101, {5'd3, 5'd2, 5'd1}, {32'hA2, 32'hA1, 32'hA0}, 3'b001, 1'b1, 5'd1, 32'hA0, 32'd4);
    tbl[4] = mk(3'b101, {5'd3, 5'd2, 5'd1}, {32'hA2, 32'hA1, 32'hA0}, 3'b100, 1'b1, 5'd3, 32'hA2, 32'd5);
    tbl[5] = mk(3'b000, {5'd3, 5'd2, 5'd1}, {32'hA2, 32'hA1, 32'hA0}, 3'b000, 1'b0, 5'd3, 32'hA2, 32'd5);
    tbl[6] = mk(3'b001, {5'd3, 5'd2, 5'd0}, {32'hA2, 32'hA1, 32'h1234}, 3'b001, 1'b0, 5'd0, 32'h1234, 32'd5);
    tbl[7] = mk(3'b011, {5'd3, 5'd5, 5'd7}, {32'hA2, 32'hDEAD_BEEF, 32'h77}, 3'b010, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'd6);
    tbl[8] = mk(3'b001, {5'd3, 5'd5, 5'd7}, {32'hA2, 32'hDEAD_BEEF, 32'h77}, 3'b001, 1'b1, 5'd7, 32'h77, 32'd7);

    // reset with every producer requesting
    rst_i      = 1'b1;
    wb_valid_i = 3'b111;
    wb_idx_i   = {5'd3, 5'd2, 5'd1};
    wb_data_i  = {32'hA2, 32'hA1, 32'hA0};
    model_reset();
    #2;
    chk("rst_ready", 32'(wb_ready_o), 32'd0);
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_rd_idx", 32'(rd_idx_o), 32'd0);
    chk("rst_rd", rd_o, 32'd0);
    chk("rst_cnt", wb_cnt_o, 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].valid, tbl[i].idx, tbl[i].data, i);
    end

    // async reset while a write is pending in the output register
    step(3'b010, {5'd3, 5'd9, 5'd7}, {32'hA2, 32'h5555_AAAA, 32'h77}, -1);
    chk("pre_rst_we", 32'(we_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("async_we", 32'(we_o), 32'd0);
    chk("async_cnt", wb_cnt_o, 32'd0);
    chk("async_rd", rd_o, 32'd0);
    chk("async_rd_idx", 32'(rd_idx_o), 32'd0);
    chk("async_ready", 32'(wb_ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();

    // fairness: all ports valid, pointer restarts at 0
    for (int i = 0; i < 9; i++) begin
      step(3'b111, {5'd13, 5'd12, 5'd11}, {32'hC2, 32'hC1, 32'hC0}, -1);
      chk("fair_grant", 32'(last_ready), 32'(1 << (i % 3)));
    end
    chk("fair_cnt", wb_cnt_o, 32'd9);

    // randomized traffic; producers hold requests until granted
    pv = '0;
    for (int k = 0; k < N; k++) begin
      pidx[k] = '0;
      pdat[k] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pv[k]) begin
          pv[k]   = ($urandom_range(0, 99) < 60);
          pidx[k] = 5'($urandom_range(0, 31));
          pdat[k] = $urandom;
        end
      end
      rix  = {pidx[2], pidx[1], pidx[0]};
      rdat = {pdat[2], pdat[1], pdat[0]};
      rw   = model_winner(pv);
      step(pv, rix, rdat, -1);
      if (rw >= 0) pv[rw] = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
